cheri_tsmap_writer: RTL
=======================

Name: cheri_tsmap_writer

Overview:
- Write-side engine for the temporal-safety (revocation) bitmap, TSMAP.
- The load-path revocation checker only reads TSMAP. This block sets or clears TSMAP bits when the allocator frees or reuses heap memory.
- It takes a byte range, converts it to 8-byte heap granules and performs word-granular read-modify-write on the TSMAP SRAM port.
- Software drives it through an MMIO shim. It shares the TSMAP port through an external arbiter using req/gnt.

Parameters:
- HeapBase, 32'h8000_0000, byte address of granule 0. TSMAP bit n covers bytes HeapBase+8n .. HeapBase+8n+7.
- TSMapSize, 1024, number of 32-bit TSMAP words. Valid word index is 0..TSMapSize-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  range request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_base_i  in  32  start byte address
- req_len_i  in  32  length in bytes
- req_set_i  in  1  1 = set bits (revoke), 0 = clear bits
- resp_valid_o  out  1  one-cycle completion pulse
- resp_err_o  out  1  range error, valid with resp_valid_o
- busy_o  out  1  operation in progress (IDLE excluded)
- tsmap_req_o  out  1  TSMAP access request
- tsmap_gnt_i  in  1  access performed in the cycle where req & gnt
- tsmap_we_o  out  1  1 = write, 0 = read
- tsmap_addr_o  out  16  TSMAP word index
- tsmap_wdata_o  out  32  write data
- tsmap_rdata_i  in  32  read data, valid the cycle after a granted read

Behaviour:
- Reset (async): FSM = IDLE. All outputs 0 except req_ready_o = 1. All internal registers cleared.
- Reset mid-operation aborts it: no response pulse, partial TSMAP updates are not rolled back.
- Address arithmetic (registered in CHECK):
  - end33 = {1'b0,base} + len - 1, computed at 33 bits.
  - gs = (base - HeapBase) >> 3.
  - ge = (end33[31:0] - HeapBase) >> 3.
  - ws = gs[31:5], bs = gs[4:0], we = ge[31:5], be = ge[4:0].
- Error when len != 0 and any of: base < HeapBase; end33[32] = 1; we >= TSMapSize.
- On error: no TSMAP access, resp_err_o = 1.
- len == 0: no access, resp_err_o = 0.
- Per-word mask for word w:
  - lo = (w == ws) ? bs : 0; hi = (w == we) ? be : 31.
  - mask = bits lo..hi inclusive.
- Write data:
  - Set: new = old | mask. Clear: new = old & ~mask.
  - Full mask (all ones) skips the read; write data is 32'hFFFF_FFFF (set) or 0 (clear).
- FSM:
  - IDLE: ready = 1. On valid & ready, latch base/len/set → CHECK.
  - CHECK: compute ws/we/bs/be and the error.
    - error or len == 0 → DONE
    - else w = ws; full mask → WR, partial → RD.
  - RD: tsmap_req = 1, we = 0, addr = w. Hold until gnt → MOD.
  - MOD: capture tsmap_rdata_i, form the write word → WR.
  - WR: tsmap_req = 1, we = 1, addr = w, wdata stable. Hold until gnt.
    - w == we → DONE
    - else w = w + 1, then RD or WR based on the new mask.
  - DONE: resp_valid_o = 1 for one cycle with resp_err_o → IDLE.
- Stall rule: while tsmap_req_o is high and gnt is low, addr, we and wdata stay constant.
- Latency, single partial word with gnt tied high:
  - accept at cycle 0; read at cycle 2; write at cycle 4; resp_valid at cycle 5.
- Each extra full word costs 1 cycle. Each extra partial word costs 3 cycles.
- req_valid_i while busy is ignored (ready = 0).
- A new request can be accepted in the cycle after DONE.
- Word index increments without wrap; the range check guarantees we < TSMapSize.

Test Plan:
- Partial word set: base=0x8000_0010, len=0x10, set=1; rdata=0x0000_0001 → read addr 0, then write addr 0 wdata 0x0000_000D; resp err=0 at cycle 5.
- Full words: base=0x8000_0000, len=0x300, set=1 → no reads; writes addr 0, 1, 2 each 0xFFFF_FFFF on consecutive cycles; resp err=0.
- Word-spanning clear: base=0x8000_00F8, len=0x10, set=0, rdata=0xFFFF_FFFF → write addr 0 wdata 0x7FFF_FFFF, then addr 1 wdata 0xFFFF_FFFE. Unaligned variant base=0x8000_00FC, len=5 gives the same two writes.
- Errors and no-op:
  - base=0x7FFF_FFF8, len=8 → resp err=1, tsmap_req never high.
  - base=0x8004_0000, len=8 → err=1.
  - base=0xFFFF_FFF8, len=0x10 → err=1 (overflow).
  - len=0 → resp err=0, no access.
- Grant stall: gnt low for 3 cycles in RD and WR → addr/we/wdata stable; req_valid pulsed while busy not accepted; final wdata correct.
- Reset mid-op: rst_ni low during WR → outputs immediately 0, ready=1 after release, no resp pulse; next request completes normally.

Source files
------------

// File: rtl/cheri_tsmap_writer.sv
// Write-side engine for the TSMAP revocation bitmap: turns a byte range into
// granule bits and applies them with word-granular read-modify-write on the TSMAP port.
module cheri_tsmap_writer #(
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter int unsigned TSMapSize = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_base_i,
    input  logic [31:0] req_len_i,
    input  logic        req_set_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic        busy_o,
    output logic        tsmap_req_o,
    input  logic        tsmap_gnt_i,
    output logic        tsmap_we_o,
    output logic [15:0] tsmap_addr_o,
    output logic [31:0] tsmap_wdata_o,
    input  logic [31:0] tsmap_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD, S_MOD, S_WR, S_DONE
    } state_e;

    state_e      state_q;
    logic [31:0] base_q, len_q;
    logic        set_q, err_q;
    logic [26:0] w_q, ws_q, wend_q;
    logic [4:0]  bs_q, be_q;
    logic [31:0] mask_q, wdata_q;

    logic [32:0] end33;
    logic [31:0] gs, ge;
    logic        err_c;
    logic [31:0] cmask, nmask, fill;
    logic [26:0] w_nxt;

    // Bits lo..hi of word w, where only the first/last word of the range is trimmed.
    function automatic logic [31:0] word_mask(input logic [26:0] w, input logic [26:0] ws,
                                              input logic [26:0] wl, input logic [4:0] bs,
                                              input logic [4:0] be);
        logic [4:0]  lo, hi;
        logic [31:0] m;
        lo = (w == ws) ? bs : 5'd0;
        hi = (w == wl) ? be : 5'd31;
        for (int i = 0; i < 32; i++) m[i] = (5'(i) >= lo) && (5'(i) <= hi);
        return m;
    endfunction

    assign end33 = {1'b0, base_q} + {1'b0, len_q} - 33'd1;
    assign gs    = (base_q - HeapBase) >> 3;
    assign ge    = (end33[31:0] - HeapBase) >> 3;
    assign err_c = (len_q != '0) &&
                   ((base_q < HeapBase) || end33[32] || (32'(ge[31:5]) >= TSMapSize));
    assign cmask = word_mask(gs[31:5], gs[31:5], ge[31:5], gs[4:0], ge[4:0]);
    assign w_nxt = w_q + 27'd1;
    assign nmask = word_mask(w_nxt, ws_q, wend_q, bs_q, be_q);
    assign fill  = set_q ? 32'hFFFF_FFFF : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            set_q   <= 1'b0;
            err_q   <= 1'b0;
            w_q     <= '0;
            ws_q    <= '0;
            wend_q  <= '0;
            bs_q    <= '0;
            be_q    <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid_i) begin
                    base_q  <= req_base_i;
                    len_q   <= req_len_i;
                    set_q   <= req_set_i;
                    err_q   <= 1'b0;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    err_q  <= err_c;
                    ws_q   <= gs[31:5];
                    wend_q <= ge[31:5];
                    bs_q   <= gs[4:0];
                    be_q   <= ge[4:0];
                    w_q    <= gs[31:5];
                    mask_q <= cmask;
                    if (err_c || len_q == '0) begin
                        state_q <= S_DONE;
                    end else if (&cmask) begin
                        wdata_q <= fill;
                        state_q <= S_WR;
                    end else begin
                        state_q <= S_RD;
                    end
                end
                S_RD: if (tsmap_gnt_i) state_q <= S_MOD;
                S_MOD: begin
                    wdata_q <= set_q ? (tsmap_rdata_i | mask_q) : (tsmap_rdata_i & ~mask_q);
                    state_q <= S_WR;
                end
                // wdata_q only changes on a granted write, so it is stable across stalls.
                S_WR: if (tsmap_gnt_i) begin
                    if (w_q == wend_q) begin
                        state_q <= S_DONE;
                    end else begin
                        w_q    <= w_nxt;
                        mask_q <= nmask;
                        if (&nmask) begin
                            wdata_q <= fill;
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign tsmap_req_o   = (state_q == S_RD) || (state_q == S_WR);
    assign tsmap_we_o    = (state_q == S_WR);
    assign tsmap_addr_o  = w_q[15:0];
    assign tsmap_wdata_o = wdata_q;
    assign resp_valid_o  = (state_q == S_DONE);
    assign resp_err_o    = (state_q == S_DONE) && err_q;

endmodule
